// File: rtl/multicycle_processor.sv
// Multi-cycle MIPS-subset core: one FSM walks FETCH/DECODE/EXEC/MEM/WB over shared datapath
// registers and reaches instruction/data memory through req/ready handshakes.
module multicycle_processor #(
  parameter logic [31:0] RESET_PC        = 32'h0040_0000,
  parameter int          INSTRET_WIDTH   = 32,
  parameter bit          HALT_ON_ILLEGAL = 1'b1
) (
  input  logic                     clock,
  input  logic                     reset,
  output logic                     imem_req,
  output logic [31:0]              imem_addr,
  input  logic                     imem_ready,
  input  logic [31:0]              imem_rdata,
  output logic                     dmem_req,
  output logic                     dmem_we,
  output logic [1:0]               dmem_size,
  output logic [31:0]              dmem_addr,
  output logic [31:0]              dmem_wdata,
  input  logic                     dmem_ready,
  input  logic [31:0]              dmem_rdata,
  input  logic [4:0]               dbg_reg_sel,
  output logic [31:0]              dbg_reg_data,
  output logic [31:0]              pc,
  output logic [INSTRET_WIDTH-1:0] instret,
  output logic                     halted
);

  // Handshake: req is high for the whole access with addr/we/size/wdata held; the access
  // completes on the first clock edge where req and ready are both high (may be the first
  // req cycle). ready without req is ignored; rdata is captured on the completing edge.

  localparam logic [2:0] S_FETCH  = 3'd0;
  localparam logic [2:0] S_DECODE = 3'd1;
  localparam logic [2:0] S_EXEC   = 3'd2;
  localparam logic [2:0] S_MEM    = 3'd3;
  localparam logic [2:0] S_WB     = 3'd4;
  localparam logic [2:0] S_HALT   = 3'd5;

  localparam logic [5:0] OP_R    = 6'h00, OP_J    = 6'h02, OP_JAL  = 6'h03, OP_BEQ  = 6'h04;
  localparam logic [5:0] OP_BNE  = 6'h05, OP_ADDI = 6'h08, OP_SLTI = 6'h0A, OP_ANDI = 6'h0C;
  localparam logic [5:0] OP_ORI  = 6'h0D, OP_LUI  = 6'h0F, OP_LB   = 6'h20, OP_LW   = 6'h23;
  localparam logic [5:0] OP_LBU  = 6'h24, OP_SB   = 6'h28, OP_SW   = 6'h2B;

  localparam logic [5:0] F_SLL = 6'h00, F_SRL = 6'h02, F_JR  = 6'h08, F_ADD = 6'h20;
  localparam logic [5:0] F_SUB = 6'h22, F_AND = 6'h24, F_OR  = 6'h25, F_SLT = 6'h2A;

  localparam logic [INSTRET_WIDTH-1:0] INSTRET_ONE = 1;

  logic [2:0]               state_q, state_d;
  logic [31:0]              pc_q, pc_d;
  logic [31:0]              ir_q, ir_d;
  logic [31:0]              a_q, a_d;
  logic [31:0]              b_q, b_d;
  logic [31:0]              imm_q, imm_d;
  logic [31:0]              alu_q, alu_d;
  logic [31:0]              mdr_q, mdr_d;
  logic [INSTRET_WIDTH-1:0] instret_q, instret_d;
  logic [31:0]              regs_q [32];

  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic        retire;

  logic [5:0]  opcode, funct;
  logic [4:0]  rs, rt, rd, shamt;
  assign opcode = ir_q[31:26];
  assign rs     = ir_q[25:21];
  assign rt     = ir_q[20:16];
  assign rd     = ir_q[15:11];
  assign shamt  = ir_q[10:6];
  assign funct  = ir_q[5:0];

  logic is_r, r_alu, is_jr, is_branch, is_j, is_jal, is_imm_alu, is_load, is_store;
  logic is_byte, legal, writes_reg;

  always_comb begin
    is_r       = (opcode == OP_R);
    r_alu      = is_r && (funct == F_SLL || funct == F_SRL || funct == F_ADD || funct == F_SUB ||
                          funct == F_AND || funct == F_OR  || funct == F_SLT);
    is_jr      = is_r && (funct == F_JR);
    is_branch  = (opcode == OP_BEQ) || (opcode == OP_BNE);
    is_j       = (opcode == OP_J);
    is_jal     = (opcode == OP_JAL);
    is_imm_alu = (opcode == OP_ADDI) || (opcode == OP_SLTI) || (opcode == OP_ANDI) ||
                 (opcode == OP_ORI)  || (opcode == OP_LUI);
    is_load    = (opcode == OP_LW) || (opcode == OP_LB) || (opcode == OP_LBU);
    is_store   = (opcode == OP_SW) || (opcode == OP_SB);
    is_byte    = (opcode == OP_LB) || (opcode == OP_LBU) || (opcode == OP_SB);
    legal      = r_alu || is_jr || is_branch || is_j || is_jal || is_imm_alu || is_load || is_store;
    writes_reg = r_alu || is_imm_alu || is_load || is_jal;
  end

  logic [31:0] rs_val, rt_val;
  assign rs_val       = (rs == 5'd0) ? 32'd0 : regs_q[rs];
  assign rt_val       = (rt == 5'd0) ? 32'd0 : regs_q[rt];
  assign dbg_reg_data = (dbg_reg_sel == 5'd0) ? 32'd0 : regs_q[dbg_reg_sel];

  // Next PC is a pure function of IR/pc/operands so any final state can commit it.
  logic [31:0] pc_plus4, next_pc;
  logic        taken;
  always_comb begin
    pc_plus4 = pc_q + 32'd4;
    taken    = ((opcode == OP_BEQ) && (a_q == b_q)) || ((opcode == OP_BNE) && (a_q != b_q));
    next_pc  = pc_plus4;
    if (is_j || is_jal) begin
      next_pc = {pc_plus4[31:28], ir_q[25:0], 2'b00};
    end else if (is_jr) begin
      next_pc = a_q;
    end else if (is_branch && taken) begin
      next_pc = pc_plus4 + {imm_q[29:0], 2'b00};
    end
  end

  logic [31:0] alu_res;
  always_comb begin
    alu_res = a_q + imm_q;
    if (is_r) begin
      case (funct)
        F_SUB:   alu_res = a_q - b_q;
        F_AND:   alu_res = a_q & b_q;
        F_OR:    alu_res = a_q | b_q;
        F_SLT:   alu_res = {31'd0, $signed(a_q) < $signed(b_q)};
        F_SLL:   alu_res = b_q << shamt;
        F_SRL:   alu_res = b_q >> shamt;
        default: alu_res = a_q + b_q;
      endcase
    end else begin
      case (opcode)
        OP_SLTI: alu_res = {31'd0, $signed(a_q) < $signed(imm_q)};
        OP_ANDI: alu_res = a_q & imm_q;
        OP_ORI:  alu_res = a_q | imm_q;
        OP_LUI:  alu_res = {imm_q[15:0], 16'h0000};
        default: alu_res = a_q + imm_q;
      endcase
    end
  end

  logic [31:0] load_val;
  always_comb begin
    case (opcode)
      OP_LB:   load_val = {{24{mdr_q[7]}}, mdr_q[7:0]};
      OP_LBU:  load_val = {24'd0, mdr_q[7:0]};
      default: load_val = mdr_q;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    ir_d      = ir_q;
    a_d       = a_q;
    b_d       = b_q;
    imm_d     = imm_q;
    alu_d     = alu_q;
    mdr_d     = mdr_q;
    instret_d = instret_q;
    rf_we     = 1'b0;
    rf_waddr  = is_jal ? 5'd31 : (is_r ? rd : rt);
    rf_wdata  = is_load ? load_val : (is_jal ? pc_plus4 : alu_q);
    retire    = 1'b0;
    case (state_q)
      S_FETCH: begin
        if (imem_ready) begin
          ir_d    = imem_rdata;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        a_d   = rs_val;
        b_d   = rt_val;
        imm_d = (opcode == OP_ANDI || opcode == OP_ORI) ? {16'd0, ir_q[15:0]}
                                                        : {{16{ir_q[15]}}, ir_q[15:0]};
        state_d = (!legal && HALT_ON_ILLEGAL) ? S_HALT : S_EXEC;
      end
      S_EXEC: begin
        alu_d = alu_res;
        if (is_load || is_store) begin
          state_d = S_MEM;
        end else if (writes_reg) begin
          state_d = S_WB;
        end else begin
          retire = 1'b1;
        end
      end
      S_MEM: begin
        if (dmem_ready) begin
          if (is_load) begin
            mdr_d   = dmem_rdata;
            state_d = S_WB;
          end else begin
            retire = 1'b1;
          end
        end
      end
      S_WB: begin
        rf_we  = 1'b1;
        retire = 1'b1;
      end
      default: state_d = S_HALT;
    endcase
    if (retire) begin
      pc_d      = next_pc;
      state_d   = S_FETCH;
      instret_d = instret_q + INSTRET_ONE;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= S_FETCH;
      pc_q      <= RESET_PC;
      ir_q      <= '0;
      a_q       <= '0;
      b_q       <= '0;
      imm_q     <= '0;
      alu_q     <= '0;
      mdr_q     <= '0;
      instret_q <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      ir_q      <= ir_d;
      a_q       <= a_d;
      b_q       <= b_d;
      imm_q     <= imm_d;
      alu_q     <= alu_d;
      mdr_q     <= mdr_d;
      instret_q <= instret_d;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) regs_q[i] <= '0;
    end else if (rf_we && (rf_waddr != 5'd0)) begin
      regs_q[rf_waddr] <= rf_wdata;
    end
  end

  // Requests are masked by reset so an abandoned access drops immediately and is never retried.
  assign imem_req   = (state_q == S_FETCH) && !reset;
  assign imem_addr  = pc_q;
  assign dmem_req   = (state_q == S_MEM) && !reset;
  assign dmem_we    = is_store;
  assign dmem_size  = is_byte ? 2'b00 : 2'b11;
  assign dmem_addr  = alu_q;
  assign dmem_wdata = b_q;
  assign pc         = pc_q;
  assign instret    = instret_q;
  assign halted     = (state_q == S_HALT);

endmodule

// File: tb/tb_multicycle_processor.sv
// Directed bench for multicycle_processor: memory responders, fetch/data scoreboards and
// register/counter checks around short hand-assembled programs.
module tb_multicycle_processor;

  localparam logic [31:0] BASE   = 32'h0040_0000;
  localparam logic [31:0] HALT_W = 32'hFC00_0000;

  logic        clock, reset;
  logic        imem_req, imem_ready;
  logic [31:0] imem_addr, imem_rdata;
  logic        dmem_req, dmem_we, dmem_ready;
  logic [1:0]  dmem_size;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic [4:0]  dbg_reg_sel;
  logic [31:0] dbg_reg_data, pc, instret;
  logic        halted;

  multicycle_processor dut (
    .clock(clock), .reset(reset),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready), .imem_rdata(imem_rdata),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_size(dmem_size), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_ready(dmem_ready), .dmem_rdata(dmem_rdata),
    .dbg_reg_sel(dbg_reg_sel), .dbg_reg_data(dbg_reg_data),
    .pc(pc), .instret(instret), .halted(halted)
  );

  int checks = 0;
  int errors = 0;
  int dmem_delay = 0;
  logic [31:0] imem   [0:63];
  logic [7:0]  dmem_b [0:255];
  logic [66:0] exp_q  [$];
  logic [31:0] exp_fq [$];

  // ---------------- clock / reset ----------------
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic chk(input string name, input logic [66:0] act, input logic [66:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic chk_reg(input string name, input logic [4:0] sel, input logic [31:0] exp);
    dbg_reg_sel = sel;
    #1;
    chk(name, {35'd0, dbg_reg_data}, {35'd0, exp});
  endtask

  task automatic start_test();
    @(negedge clock);
    reset = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    for (int i = 0; i < 64; i++) imem[i] = HALT_W;
    for (int i = 0; i < 256; i++) dmem_b[i] = 8'h00;
    dmem_delay = 0;
  endtask

  task automatic release_reset();
    @(negedge clock);
    reset = 1'b0;
    #1;
  endtask

  task automatic run(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  // ---------------- driver helpers ----------------
  function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  function automatic logic [31:0] enc_r(input logic [4:0] rs, input logic [4:0] rt,
                                        input logic [4:0] rd, input logic [4:0] sh,
                                        input logic [5:0] fn);
    return {6'h00, rs, rt, rd, sh, fn};
  endfunction

  function automatic logic [31:0] enc_j(input logic [5:0] op, input logic [25:0] tgt);
    return {op, tgt};
  endfunction

  function automatic logic [31:0] fetch_word(input logic [31:0] a);
    logic [31:0] off;
    off = a - BASE;
    if (off < 32'd256) return imem[off[7:2]];
    return HALT_W;
  endfunction

  task automatic push_d(input logic we, input logic [1:0] sz, input logic [31:0] a,
                        input logic [31:0] wd);
    exp_q.push_back({we, sz, a, wd});
  endtask

  // ---------------- memory responders ----------------
  initial begin
    imem_ready = 1'b1;
    imem_rdata = HALT_W;
    forever begin
      @(negedge clock);
      imem_rdata = fetch_word(imem_addr);
    end
  end

  initial begin
    int wait_cnt;
    logic [7:0] a;
    wait_cnt   = 0;
    dmem_ready = 1'b0;
    dmem_rdata = 32'd0;
    forever begin
      @(negedge clock);
      if (dmem_req) begin
        if (wait_cnt >= dmem_delay) begin
          dmem_ready = 1'b1;
          a = dmem_addr[7:0];
          if (dmem_we) begin
            dmem_b[a] = dmem_wdata[7:0];
            if (dmem_size == 2'b11) begin
              dmem_b[a + 8'd1] = dmem_wdata[15:8];
              dmem_b[a + 8'd2] = dmem_wdata[23:16];
              dmem_b[a + 8'd3] = dmem_wdata[31:24];
            end
          end else if (dmem_size == 2'b11) begin
            dmem_rdata = {dmem_b[a + 8'd3], dmem_b[a + 8'd2], dmem_b[a + 8'd1], dmem_b[a]};
          end else begin
            dmem_rdata = {24'hA5A5A5, dmem_b[a]};
          end
        end else begin
          dmem_ready = 1'b0;
          wait_cnt++;
        end
      end else begin
        dmem_ready = 1'b0;
        wait_cnt   = 0;
      end
    end
  end

  // ---------------- scoreboard monitors ----------------
  initial begin
    logic [66:0] cur, hold;
    logic        hold_v;
    hold_v = 1'b0;
    hold   = '0;
    forever begin
      @(negedge clock);
      #2;
      if (dmem_req) begin
        cur = {dmem_we, dmem_size, dmem_addr, dmem_we ? dmem_wdata : 32'd0};
        if (hold_v) chk("dmem_stable", cur, hold);
        else begin
          hold   = cur;
          hold_v = 1'b1;
        end
        if (dmem_ready) begin
          hold_v = 1'b0;
          if (exp_q.size() == 0) begin
            chk("dmem_unexpected", cur, 67'd0);
          end else begin
            chk("dmem_txn", cur, exp_q.pop_front());
          end
        end
      end else begin
        hold_v = 1'b0;
      end
    end
  end

  initial begin
    forever begin
      @(negedge clock);
      #2;
      if (imem_req && imem_ready && exp_fq.size() > 0) begin
        chk("fetch_addr", {35'd0, imem_addr}, {35'd0, exp_fq.pop_front()});
      end
    end
  end

  // ---------------- directed tests ----------------
  initial begin
    reset       = 1'b1;
    dbg_reg_sel = 5'd0;

    // Reset state plus ALU program
    start_test();
    chk("imem_req_in_reset", {66'd0, imem_req}, 67'd0);
    imem[0]  = enc_i(6'h08, 5'd0, 5'd8, 16'd5);
    imem[1]  = enc_i(6'h08, 5'd0, 5'd9, 16'hFFFD);
    imem[2]  = enc_r(5'd8, 5'd9, 5'd10, 5'd0, 6'h20);
    imem[3]  = enc_r(5'd8, 5'd9, 5'd14, 5'd0, 6'h22);
    imem[4]  = enc_r(5'd8, 5'd9, 5'd15, 5'd0, 6'h24);
    imem[5]  = enc_r(5'd8, 5'd9, 5'd16, 5'd0, 6'h25);
    imem[6]  = enc_r(5'd9, 5'd8, 5'd17, 5'd0, 6'h2A);
    imem[7]  = enc_r(5'd0, 5'd8, 5'd18, 5'd4, 6'h00);
    imem[8]  = enc_r(5'd0, 5'd9, 5'd19, 5'd28, 6'h02);
    imem[9]  = enc_i(6'h0F, 5'd0, 5'd20, 16'h1234);
    imem[10] = enc_i(6'h0D, 5'd20, 5'd20, 16'h8001);
    imem[11] = enc_i(6'h0C, 5'd9, 5'd21, 16'hFFFF);
    imem[12] = enc_i(6'h0A, 5'd9, 5'd22, 16'h0000);
    imem[13] = enc_i(6'h08, 5'd0, 5'd0, 16'd7);
    release_reset();
    chk("rst_imem_req", {66'd0, imem_req}, 67'd1);
    chk("rst_pc", {35'd0, pc}, {35'd0, BASE});
    chk("rst_instret", {35'd0, instret}, 67'd0);
    chk("rst_halted", {66'd0, halted}, 67'd0);
    run(11);
    chk("t2_instret_11", {35'd0, instret}, 67'd2);
    chk_reg("t2_r10_early", 5'd10, 32'd0);
    run(1);
    chk("t2_instret_12", {35'd0, instret}, 67'd3);
    chk_reg("t2_r10", 5'd10, 32'd2);
    run(44);
    chk("t2_instret_56", {35'd0, instret}, 67'd14);
    chk_reg("sub", 5'd14, 32'd8);
    chk_reg("and", 5'd15, 32'd5);
    chk_reg("or", 5'd16, 32'hFFFF_FFFD);
    chk_reg("slt", 5'd17, 32'd1);
    chk_reg("sll", 5'd18, 32'h50);
    chk_reg("srl", 5'd19, 32'hF);
    chk_reg("lui_ori", 5'd20, 32'h1234_8001);
    chk_reg("andi_zext", 5'd21, 32'h0000_FFFD);
    chk_reg("slti", 5'd22, 32'd1);
    chk_reg("r0_zero", 5'd0, 32'd0);

    // sw/lw with three wait cycles on the data side
    start_test();
    dmem_delay = 3;
    imem[0] = enc_i(6'h08, 5'd0, 5'd8, 16'd5);
    imem[1] = enc_i(6'h2B, 5'd0, 5'd8, 16'h0010);
    imem[2] = enc_i(6'h23, 5'd0, 5'd11, 16'h0010);
    push_d(1'b1, 2'b11, 32'h10, 32'd5);
    push_d(1'b0, 2'b11, 32'h10, 32'd0);
    release_reset();
    run(18);
    chk("t3_instret_18", {35'd0, instret}, 67'd2);
    chk_reg("t3_r11_early", 5'd11, 32'd0);
    run(1);
    chk("t3_instret_19", {35'd0, instret}, 67'd3);
    chk_reg("t3_lw", 5'd11, 32'd5);

    // Byte loads and stores
    start_test();
    dmem_b[8'h80] = 8'h80;
    imem[0] = enc_i(6'h08, 5'd0, 5'd8, 16'd5);
    imem[1] = enc_i(6'h20, 5'd0, 5'd12, 16'h0080);
    imem[2] = enc_i(6'h24, 5'd0, 5'd13, 16'h0080);
    imem[3] = enc_i(6'h28, 5'd0, 5'd8, 16'h0081);
    push_d(1'b0, 2'b00, 32'h80, 32'd0);
    push_d(1'b0, 2'b00, 32'h80, 32'd0);
    push_d(1'b1, 2'b00, 32'h81, 32'd5);
    release_reset();
    run(18);
    chk("t4_instret", {35'd0, instret}, 67'd4);
    chk_reg("lb_sext", 5'd12, 32'hFFFF_FF80);
    chk_reg("lbu_zext", 5'd13, 32'h0000_0080);
    chk("sb_mem", {59'd0, dmem_b[8'h81]}, 67'h05);

    // Backward beq loop
    start_test();
    imem[0] = 32'h0000_0000;
    imem[1] = enc_i(6'h08, 5'd9, 5'd9, 16'd1);
    imem[2] = enc_i(6'h04, 5'd0, 5'd0, 16'hFFFE);
    exp_fq.push_back(BASE);
    exp_fq.push_back(BASE + 32'h4);
    exp_fq.push_back(BASE + 32'h8);
    exp_fq.push_back(BASE + 32'h4);
    exp_fq.push_back(BASE + 32'h8);
    exp_fq.push_back(BASE + 32'h4);
    release_reset();
    run(20);
    chk_reg("beq_loop_r9", 5'd9, 32'd2);
    chk("beq_fetch_q_empty", 67'(exp_fq.size()), 67'd0);

    // Not-taken beq, j, jal, jr
    start_test();
    imem[0] = enc_i(6'h08, 5'd0, 5'd8, 16'd3);
    imem[1] = enc_i(6'h08, 5'd0, 5'd9, 16'd4);
    imem[2] = enc_i(6'h04, 5'd8, 5'd9, 16'd5);
    imem[3] = enc_j(6'h02, 26'h010_0004);
    imem[4] = enc_j(6'h03, 26'h010_0008);
    imem[5] = enc_i(6'h08, 5'd0, 5'd10, 16'd9);
    imem[8] = enc_r(5'd31, 5'd0, 5'd0, 5'd0, 6'h08);
    exp_fq.push_back(BASE);
    exp_fq.push_back(BASE + 32'h04);
    exp_fq.push_back(BASE + 32'h08);
    exp_fq.push_back(BASE + 32'h0C);
    exp_fq.push_back(BASE + 32'h10);
    exp_fq.push_back(BASE + 32'h20);
    exp_fq.push_back(BASE + 32'h14);
    exp_fq.push_back(BASE + 32'h18);
    release_reset();
    run(30);
    chk_reg("jal_r31", 5'd31, BASE + 32'h14);
    chk_reg("after_jr_r10", 5'd10, 32'd9);
    chk("jump_instret", {35'd0, instret}, 67'd7);
    chk("jump_halted", {66'd0, halted}, 67'd1);
    chk("jump_halt_pc", {35'd0, pc}, {35'd0, BASE + 32'h18});
    chk("jump_fetch_q_empty", 67'(exp_fq.size()), 67'd0);

    // Illegal opcode halts and stays quiet
    start_test();
    release_reset();
    run(1);
    chk("ill_not_yet_halted", {66'd0, halted}, 67'd0);
    run(1);
    chk("ill_halted", {66'd0, halted}, 67'd1);
    chk("ill_pc", {35'd0, pc}, {35'd0, BASE});
    chk("ill_instret", {35'd0, instret}, 67'd0);
    for (int i = 0; i < 20; i++) begin
      run(1);
      chk("halt_reqs_low", {65'd0, imem_req, dmem_req}, 67'd0);
    end

    // Reset in the middle of a stalled lw
    start_test();
    dmem_delay = 10;
    imem[0] = enc_i(6'h23, 5'd0, 5'd11, 16'h0010);
    release_reset();
    run(5);
    chk("midlw_req", {66'd0, dmem_req}, 67'd1);
    chk("midlw_addr", {35'd0, dmem_addr}, 67'h10);
    reset = 1'b1;
    run(1);
    chk("midlw_req_dropped", {66'd0, dmem_req}, 67'd0);
    chk("midlw_pc_reset", {35'd0, pc}, {35'd0, BASE});
    run(3);
    chk("midlw_not_retried", {66'd0, dmem_req}, 67'd0);

    chk("dmem_q_empty", 67'(exp_q.size()), 67'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
